// File: rtl/layer_mac_sequencer.sv
// layer_mac_sequencer: one fully connected layer computed on a single shared
// multiply-accumulate unit. Weights stream from an external synchronous ROM
// (data one cycle after the read strobe). Each neuron's dot product plus bias
// is requantized, saturated, optionally ReLU-clamped, and the full output
// vector is offered on a valid/ready stream.
module layer_mac_sequencer #(
    parameter int WIDTH      = 16,
    parameter int FRACTION   = 14,
    parameter int W_WIDTH    = 8,
    parameter int W_FRAC     = 7,
    parameter int INPUT_NUM  = 4,
    parameter int NODE_NUM   = 3,
    parameter int RELU       = 0,
    parameter int ADDR_WIDTH = $clog2(NODE_NUM*(INPUT_NUM+1))
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [WIDTH*INPUT_NUM-1:0]  x,
    output logic                        w_rd_en,
    output logic [ADDR_WIDTH-1:0]       w_addr,
    input  logic [W_WIDTH-1:0]          w_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [WIDTH*NODE_NUM-1:0]   out_data,
    output logic                        busy
);

    localparam int IDX_W  = $clog2(INPUT_NUM+1);
    localparam int NODE_W = (NODE_NUM > 1) ? $clog2(NODE_NUM) : 1;
    localparam int PROD_W = WIDTH + W_WIDTH;
    localparam int ACC_W  = PROD_W + $clog2(INPUT_NUM+1);

    // Bias operand: constant 1.0 in the activation format.
    localparam logic signed [WIDTH-1:0] ONE_S =
        {{(WIDTH-1){1'b0}}, 1'b1} << FRACTION;
    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
    localparam logic [IDX_W-1:0]      IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};
    localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(INPUT_NUM);
    localparam logic [NODE_W-1:0]     NODE_ONE = {{(NODE_W-1){1'b0}}, 1'b1};
    localparam logic [NODE_W-1:0]     NODE_LAST = NODE_W'(NODE_NUM-1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        LAST  = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t                         state_r;
    logic [NODE_W-1:0]              node_r;
    logic [IDX_W-1:0]               idx_r;
    logic signed [ACC_W-1:0]        acc_r;
    logic [WIDTH*INPUT_NUM-1:0]     x_r;

    logic [IDX_W-1:0]               op_sel_s;
    logic signed [WIDTH-1:0]        operand_s;
    logic signed [PROD_W-1:0]       product_s;
    logic signed [ACC_W-1:0]        prod_ext_s;
    logic [WIDTH-1:0]               requant_s;

    // Shift back to the activation format, saturate, then optional ReLU.
    function automatic logic [WIDTH-1:0] requantize(
        input logic signed [ACC_W-1:0] a,
        input logic                    relu_en
    );
        logic signed [ACC_W-1:0] s;
        logic [WIDTH-1:0]        r;
        s = a >>> W_FRAC;
        if (s > SAT_MAX) begin
            r = SAT_MAX[WIDTH-1:0];
        end else if (s < SAT_MIN) begin
            r = SAT_MIN[WIDTH-1:0];
        end else begin
            r = s[WIDTH-1:0];
        end
        if (relu_en && r[WIDTH-1]) begin
            r = {WIDTH{1'b0}};
        end else begin
            r = r;
        end
        return r;
    endfunction

    assign in_ready = (state_r == IDLE);

    // Pick the operand whose weight arrives this cycle (ROM data lags by one).
    always_comb begin
        op_sel_s  = {IDX_W{1'b0}};
        operand_s = ONE_S;
        if (state_r == LAST) begin
            op_sel_s = IDX_LAST;
        end else begin
            op_sel_s = idx_r - IDX_ONE;
        end
        for (int k = 0; k < INPUT_NUM; k++) begin
            if (op_sel_s == IDX_W'(k)) begin
                operand_s = x_r[k*WIDTH +: WIDTH];
            end else begin
                operand_s = operand_s;
            end
        end
    end

    // Shared signed multiplier, sign-extended to accumulator width.
    always_comb begin
        product_s  = operand_s * $signed(w_data);
        prod_ext_s = {{(ACC_W-PROD_W){product_s[PROD_W-1]}}, product_s};
        requant_s  = requantize(acc_r, (RELU != 0));
    end

    // Sequencer FSM: drives ROM reads, accumulation, result slots and handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            node_r    <= {NODE_W{1'b0}};
            idx_r     <= {IDX_W{1'b0}};
            acc_r     <= {ACC_W{1'b0}};
            x_r       <= {(WIDTH*INPUT_NUM){1'b0}};
            w_rd_en   <= 1'b0;
            w_addr    <= {ADDR_WIDTH{1'b0}};
            out_valid <= 1'b0;
            out_data  <= {(WIDTH*NODE_NUM){1'b0}};
            busy      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        x_r     <= x;
                        node_r  <= {NODE_W{1'b0}};
                        idx_r   <= {IDX_W{1'b0}};
                        acc_r   <= {ACC_W{1'b0}};
                        w_rd_en <= 1'b1;
                        w_addr  <= {ADDR_WIDTH{1'b0}};
                        busy    <= 1'b1;
                        state_r <= RUN;
                    end
                end
                RUN: begin
                    if (idx_r != {IDX_W{1'b0}}) begin
                        acc_r <= acc_r + prod_ext_s;
                    end
                    if (idx_r == IDX_LAST) begin
                        w_rd_en <= 1'b0;
                        state_r <= LAST;
                    end else begin
                        idx_r  <= idx_r + IDX_ONE;
                        w_addr <= w_addr + ADDR_ONE;
                    end
                end
                LAST: begin
                    acc_r   <= acc_r + prod_ext_s;
                    state_r <= WRITE;
                end
                WRITE: begin
                    for (int k = 0; k < NODE_NUM; k++) begin
                        if (node_r == NODE_W'(k)) begin
                            out_data[k*WIDTH +: WIDTH] <= requant_s;
                        end
                    end
                    acc_r <= {ACC_W{1'b0}};
                    idx_r <= {IDX_W{1'b0}};
                    if (node_r == NODE_LAST) begin
                        out_valid <= 1'b1;
                        state_r   <= DONE;
                    end else begin
                        node_r  <= node_r + NODE_ONE;
                        w_rd_en <= 1'b1;
                        w_addr  <= w_addr + ADDR_ONE;
                        state_r <= RUN;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state_r   <= IDLE;
                    end
                end
                default: begin
                    w_rd_en   <= 1'b0;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

endmodule
